// File: rtl/tour_cmd_sequencer.sv
// Plays a solved knight's tour back as motion commands (vertical leg, then horizontal leg)
// and hands the command channel to the UART whenever no tour is running.
module tour_cmd_sequencer #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);

    typedef enum logic [2:0] {
        IDLE,
        LEG1,
        WAIT1_CLR,
        WAIT1_RESP,
        LEG2,
        WAIT2_CLR,
        WAIT2_RESP
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [7:0] HEAD_N     = 8'h00;
    localparam logic [7:0] HEAD_W     = 8'h3F;
    localparam logic [7:0] HEAD_S     = 8'h7F;
    localparam logic [7:0] HEAD_E     = 8'hBF;

    state_t      state;
    logic [15:0] tour_cmd;
    logic [15:0] leg2_cmd;
    logic        tour_cmd_rdy;

    logic        move_valid;
    logic        dx_neg, dy_neg;
    logic [3:0]  dx_mag, dy_mag;
    logic [15:0] leg1_dec, leg2_dec;
    logic        last_move;

    assign last_move  = (mv_indx == IDX_W'(NUM_MOVES - 1));
    assign move_valid = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

    // Knight move bit -> signed (dx,dy) split into sign and magnitude.
    always_comb begin
        dx_neg = 1'b0;
        dy_neg = 1'b0;
        dx_mag = 4'd0;
        dy_mag = 4'd0;
        case (move)
            8'h01: begin dx_mag = 4'd1; dy_mag = 4'd2; end
            8'h02: begin dx_neg = 1'b1; dx_mag = 4'd1; dy_mag = 4'd2; end
            8'h04: begin dx_neg = 1'b1; dx_mag = 4'd2; dy_mag = 4'd1; end
            8'h08: begin dx_neg = 1'b1; dx_mag = 4'd2; dy_neg = 1'b1; dy_mag = 4'd1; end
            8'h10: begin dx_neg = 1'b1; dx_mag = 4'd1; dy_neg = 1'b1; dy_mag = 4'd2; end
            8'h20: begin dx_mag = 4'd1; dy_neg = 1'b1; dy_mag = 4'd2; end
            8'h40: begin dx_mag = 4'd2; dy_neg = 1'b1; dy_mag = 4'd1; end
            8'h80: begin dx_mag = 4'd2; dy_mag = 4'd1; end
            default: ;
        endcase
        leg1_dec = {OP_MOVE,    dy_neg ? HEAD_S : HEAD_N, dy_mag};
        leg2_dec = {OP_FANFARE, dx_neg ? HEAD_W : HEAD_E, dx_mag};
    end

    // Leg 2 is captured together with leg 1 so it cannot change if the solver output glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mv_indx      <= '0;
            tour_cmd     <= 16'h0000;
            leg2_cmd     <= 16'h0000;
            tour_cmd_rdy <= 1'b0;
            tour_busy    <= 1'b0;
            tour_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx   <= '0;
                        tour_busy <= 1'b1;
                        tour_err  <= 1'b0;
                        state     <= LEG1;
                    end
                end
                LEG1: begin
                    if (!move_valid) begin
                        tour_err  <= 1'b1;
                        tour_busy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tour_cmd     <= leg1_dec;
                        leg2_cmd     <= leg2_dec;
                        tour_cmd_rdy <= 1'b1;
                        state        <= WAIT1_CLR;
                    end
                end
                WAIT1_CLR: begin
                    if (clr_cmd_rdy) begin
                        tour_cmd_rdy <= 1'b0;
                        state        <= WAIT1_RESP;
                    end
                end
                WAIT1_RESP: begin
                    if (send_resp) state <= LEG2;
                end
                LEG2: begin
                    tour_cmd     <= leg2_cmd;
                    tour_cmd_rdy <= 1'b1;
                    state        <= WAIT2_CLR;
                end
                WAIT2_CLR: begin
                    if (clr_cmd_rdy) begin
                        tour_cmd_rdy <= 1'b0;
                        state        <= WAIT2_RESP;
                    end
                end
                WAIT2_RESP: begin
                    if (send_resp) begin
                        if (last_move) begin
                            tour_busy <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 1'b1;
                            state   <= LEG1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The UART owns the channel only while idle, with zero-latency pass-through.
    assign cmd              = (state == IDLE) ? cmd_UART     : tour_cmd;
    assign cmd_rdy          = (state == IDLE) ? cmd_rdy_UART : tour_cmd_rdy;
    assign clr_cmd_rdy_UART = (state == IDLE) ? clr_cmd_rdy  : 1'b0;
    assign resp             = ((state == IDLE) || ((state == WAIT2_RESP) && last_move)) ? 8'h5A : 8'hA5;

endmodule

// File: doc/tour_cmd_sequencer.md
Name: tour_cmd_sequencer

Overview:
- Sits between the tour solver and the motion command path.
- After the solver asserts done, it walks the solved move list by driving the solver's move index. Each knight move becomes two motion commands: a vertical leg, then a horizontal leg.
- Each command is issued through a ready/clear/response handshake.
- When no tour is running, UART-originated commands pass straight through, so the block arbitrates the single command channel between UART and tour playback.

Parameters:
- NUM_MOVES, 24, number of moves to play (5x5 board minus start square).
- IDX_W, 5, width of the move index.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_tour  input  1  one-cycle pulse; solver done, begin playback
- move  input  8  one-hot knight move for current mv_indx (combinational from solver)
- mv_indx  output  IDX_W  move index presented to solver
- cmd_UART  input  16  command from UART wrapper
- cmd_rdy_UART  input  1  UART command valid
- clr_cmd_rdy_UART  output  1  pulse; consume UART command
- cmd  output  16  command to motion controller
- cmd_rdy  output  1  command valid to motion controller
- clr_cmd_rdy  input  1  motion controller accepted command
- send_resp  input  1  motion controller finished command
- resp  output  8  response byte returned to UART
- tour_busy  output  1  high while playback active
- tour_err  output  1  sticky; illegal move encoding seen

Behaviour:
- Reset values: mv_indx=0, cmd_rdy=0, clr_cmd_rdy_UART=0, tour_busy=0, tour_err=0, state=IDLE. resp is combinational and reads 8'h5A in IDLE.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: MOVE=4'h2, MOVE_FANFARE=4'h3.
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode, as (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Leg 1 is MOVE, heading N if dy>0 else S, squares=|dy|.
- Leg 2 is MOVE_FANFARE, heading E if dx>0 else W, squares=|dx|.
- States:
  - IDLE:
    - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART.
    - clr_cmd_rdy_UART=clr_cmd_rdy (pass-through, zero latency).
    - start_tour -> mv_indx=0, tour_busy=1, go to LEG1. start_tour has priority over a pending UART command; that command remains pending (not cleared) until return to IDLE.
  - LEG1:
    - If move is not one-hot, set tour_err, clear tour_busy, go to IDLE.
    - Otherwise drive the leg-1 command and assert cmd_rdy, then go to WAIT1_CLR.
  - WAIT1_CLR: hold cmd/cmd_rdy until clr_cmd_rdy; then drop cmd_rdy the next cycle and go to WAIT1_RESP.
  - WAIT1_RESP: on send_resp go to LEG2.
  - LEG2 / WAIT2_CLR / WAIT2_RESP: same as leg 1 using the leg-2 command. On send_resp:
    - if mv_indx==NUM_MOVES-1, clear tour_busy and go to IDLE;
    - otherwise mv_indx+=1 and go to LEG1.
- cmd is registered from the decode and stable from cmd_rdy assertion through the clr_cmd_rdy cycle.
- resp:
  - 8'hA5 while tour_busy, except 8'h5A during WAIT2_RESP of the last move.
  - 8'h5A in IDLE.
  - Meaningful only in the cycle send_resp is seen.
- UART signals are ignored while tour_busy. clr_cmd_rdy_UART is forced 0 while tour_busy.
- start_tour while tour_busy is ignored.
- clr_cmd_rdy in the same cycle cmd_rdy first rises is accepted.
- send_resp arriving before clr_cmd_rdy is ignored (no state change).
- mv_indx never exceeds NUM_MOVES-1 and does not wrap.
- tour_err clears only on reset or the next start_tour.
- Asynchronous reset mid-tour returns everything to reset values immediately, with no residual cmd_rdy.

Test Plan:
- IDLE pass-through: cmd_UART=16'h2003, cmd_rdy_UART=1, clr_cmd_rdy=1 -> cmd=16'h2003, cmd_rdy=1 and clr_cmd_rdy_UART=1 in the same cycle; tour_busy=0.
- Single-move sequence: start_tour with move=8'h01, handshake both legs -> cmd=16'h2002 (N,2), then 16'h3BF1 (E,1, fanfare); resp=8'hA5; mv_indx 0->1 after the second send_resp.
- Move 8'h08 -> 16'h27F1 (S,1), then 16'h33F2 (W,2).
- Full tour: model with 24 moves, auto-responding motion model -> 48 commands issued in order. After the last send_resp: resp=8'h5A, tour_busy=0, mv_indx=23.
- Illegal move: move=8'h03 at mv_indx=5 -> no cmd_rdy, tour_err=1, state IDLE; the next start_tour clears tour_err.
- Arbitration and reset: a UART request pending during a tour is not forwarded and clr_cmd_rdy_UART stays 0; after the tour it passes through. Asserting rst_n=0 during WAIT2_CLR -> cmd_rdy=0, mv_indx=0, tour_busy=0 immediately.
